// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the RV32E load/store stage.
package lsu_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Bus bundles around the load/store stage: EXU in, memory port, WBU out.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds valid and its payload stable until that edge.
interface lsu_exu_if #(parameter int DW = 32);
  logic          exu_valid;
  logic          exu_ready;
  logic [31:0]   exu_inst;
  logic [DW-1:0] exu_result;
  logic [DW-1:0] exu_store_data;
  logic [31:0]   exu_next_pc;
  logic [63:0]   exu_num;

  modport master (output exu_valid, exu_inst, exu_result, exu_store_data, exu_next_pc, exu_num,
                  input  exu_ready);
  modport slave  (input  exu_valid, exu_inst, exu_result, exu_store_data, exu_next_pc, exu_num,
                  output exu_ready);
endinterface

interface lsu_mem_if #(parameter int AW = 32, parameter int DW = 32);
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_wen;
  logic [DW-1:0]   mem_req_wdata;
  logic [DW/8-1:0] mem_req_wstrb;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_data;
  logic            mem_resp_err;

  modport master (output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
                  input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err);
  modport slave  (input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
                  output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err);
endinterface

interface lsu_wbu_if #(parameter int AW = 32, parameter int DW = 32);
  logic          wbu_valid;
  logic          wbu_ready;
  logic [DW-1:0] wbu_wdata;
  logic [31:0]   wbu_inst;
  logic [31:0]   wbu_next_pc;
  logic [63:0]   wbu_num;
  logic [AW-1:0] wbu_sim_addr;

  modport master (output wbu_valid, wbu_wdata, wbu_inst, wbu_next_pc, wbu_num, wbu_sim_addr,
                  input  wbu_ready);
  modport slave  (input  wbu_valid, wbu_wdata, wbu_inst, wbu_next_pc, wbu_num, wbu_sim_addr,
                  output wbu_ready);
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  f3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] resp_data_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_value_o
);

  logic [31:0] shifted;

  // Misaligned halves/words simply lose the lanes that fall off the top.
  assign shifted = resp_data_i >> {off_i, 3'b000};

  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = store_data_i;
    case (f3_i)
      F3_B: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      F3_H: begin
        wstrb_o = 4'b0011 << off_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_value_o = shifted;
    case (f3_i)
      F3_B:    load_value_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_value_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_value_o = shifted;
      F3_BU:   load_value_o = {24'h0, shifted[7:0]};
      F3_HU:   load_value_o = {16'h0, shifted[15:0]};
      default: load_value_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: holds one instruction, performs at most one memory
// access for it, then offers the result to write-back.
module lsu_stage
  import lsu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [63:0] RESET_NUM  = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  lsu_exu_if.slave    exu,
  lsu_mem_if.master   mem,
  lsu_wbu_if.master   wbu,
  output logic [31:0] lsu_hazard_inst,
  output logic        lsu_fault,
  output lsu_state_e  dbg_state_o
);

  lsu_state_e            state_q, state_d;
  logic [31:0]           inst_q, inst_d;
  logic [31:0]           next_pc_q, next_pc_d;
  logic [63:0]           num_q, num_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] store_data_q, store_data_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] sim_addr_q, sim_addr_d;
  logic                  fault_q, fault_d;

  logic [6:0]  opcode_in;
  logic        is_store;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  assign opcode_in = exu.exu_inst[6:0];
  assign is_store  = (inst_q[6:0] == OP_STORE);

  lsu_align u_align (
    .f3_i         (inst_q[14:12]),
    .off_i        (result_q[1:0]),
    .store_data_i (store_data_q),
    .resp_data_i  (mem.mem_resp_data),
    .wstrb_o      (al_wstrb),
    .wdata_o      (al_wdata),
    .load_value_o (al_load)
  );

  always_comb begin
    state_d      = state_q;
    inst_d       = inst_q;
    next_pc_d    = next_pc_q;
    num_d        = num_q;
    result_d     = result_q;
    store_data_d = store_data_q;
    wdata_d      = wdata_q;
    sim_addr_d   = sim_addr_q;
    fault_d      = fault_q;
    case (state_q)
      IDLE: begin
        if (exu.exu_valid) begin
          inst_d       = exu.exu_inst;
          next_pc_d    = exu.exu_next_pc;
          num_d        = exu.exu_num;
          result_d     = exu.exu_result;
          store_data_d = exu.exu_store_data;
          if (opcode_in == OP_LOAD || opcode_in == OP_STORE) begin
            state_d    = REQ;
            sim_addr_d = exu.exu_result[ADDR_WIDTH-1:0];
          end else begin
            state_d    = OUT;
            wdata_d    = exu.exu_result;
            sim_addr_d = '0;
          end
        end
      end
      REQ: begin
        if (mem.mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem.mem_resp_valid) begin
          state_d = OUT;
          if (mem.mem_resp_err) begin
            wdata_d = '0;
            fault_d = 1'b1;
          end else if (is_store) begin
            wdata_d = '0;
          end else begin
            wdata_d = al_load;
          end
        end
      end
      OUT: begin
        if (wbu.wbu_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      inst_q       <= '0;
      next_pc_q    <= '0;
      num_q        <= RESET_NUM;
      result_q     <= '0;
      store_data_q <= '0;
      wdata_q      <= '0;
      sim_addr_q   <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      next_pc_q    <= next_pc_d;
      num_q        <= num_d;
      result_q     <= result_d;
      store_data_q <= store_data_d;
      wdata_q      <= wdata_d;
      sim_addr_q   <= sim_addr_d;
      fault_q      <= fault_d;
    end
  end

  assign exu.exu_ready     = (state_q == IDLE);
  assign mem.mem_req_valid = (state_q == REQ);
  assign mem.mem_req_addr  = result_q[ADDR_WIDTH-1:0];
  assign mem.mem_req_wen   = is_store;
  assign mem.mem_req_wdata = al_wdata;
  assign mem.mem_req_wstrb = is_store ? al_wstrb : '0;

  assign wbu.wbu_valid    = (state_q == OUT);
  assign wbu.wbu_wdata    = wdata_q;
  assign wbu.wbu_inst     = inst_q;
  assign wbu.wbu_next_pc  = next_pc_q;
  assign wbu.wbu_num      = num_q;
  assign wbu.wbu_sim_addr = sim_addr_q;

  assign lsu_hazard_inst = (state_q == IDLE) ? 32'h0 : inst_q;
  assign lsu_fault       = fault_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed cases, randomized loads/stores,
// reset during an access and sticky fault behaviour.
module tb_lsu_stage;
  import lsu_pkg::*;

  localparam logic [63:0] RST_NUM = 64'h0000_0000_0000_00A5;
  localparam int          W       = 192;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  lsu_exu_if exu_if ();
  lsu_mem_if mem_if ();
  lsu_wbu_if wbu_if ();

  logic [31:0] hazard;
  logic        fault;
  lsu_state_e  dbg_state;

  lsu_stage #(.RESET_NUM(RST_NUM)) dut (
    .clock           (clk),
    .reset           (rst),
    .exu             (exu_if),
    .mem             (mem_if),
    .wbu             (wbu_if),
    .lsu_hazard_inst (hazard),
    .lsu_fault       (fault),
    .dbg_state_o     (dbg_state)
  );

  // {inst, num, wdata, sim_addr, next_pc}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int           chk_cnt = 0;
  int           err_cnt = 0;
  logic [63:0]  num_ctr = 64'h100;
  bit           exp_fault = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b[0:6];
    logic [31:0] w;
    int          o;
    for (int i = 0; i < 7; i++) b[i] = (i < 4) ? d[8*i +: 8] : 8'h00;
    o = int'(off);
    w = {b[o+3], b[o+2], b[o+1], b[o]};
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    int         sz;
    if (f3 == 3'b010) return 4'hF;
    sz = (f3 == 3'b000) ? 1 : 2;
    s  = 4'h0;
    for (int i = 0; i < 4; i++) if (i >= int'(off) && i < int'(off) + sz) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Scoreboard: every WBU handshake retires the oldest expected entry.
  always @(negedge clk) begin
    if (wbu_if.wbu_valid && wbu_if.wbu_ready) begin
      if (exp_q.size() == 0) begin
        check("wbu_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wbu_inst",     64'(wbu_if.wbu_inst),     64'(mon_e[191:160]));
        check("wbu_num",      wbu_if.wbu_num,           mon_e[159:96]);
        check("wbu_wdata",    64'(wbu_if.wbu_wdata),    64'(mon_e[95:64]));
        check("wbu_sim_addr", 64'(wbu_if.wbu_sim_addr), 64'(mon_e[63:32]));
        check("wbu_next_pc",  64'(wbu_if.wbu_next_pc),  64'(mon_e[31:0]));
      end
    end
  end

  task automatic run_inst(input logic [31:0] inst, input logic [31:0] res,
                          input logic [31:0] sdata, input logic [31:0] rdata, input bit err,
                          input int req_dly, input int out_dly, input logic [31:0] exp_wb,
                          input logic [3:0] exp_strb, input logic [31:0] exp_bus);
    bit          is_mem, is_st;
    logic [31:0] pc, exp_sim;
    is_mem  = (inst[6:0] == OP_LOAD) || (inst[6:0] == OP_STORE);
    is_st   = (inst[6:0] == OP_STORE);
    pc      = $urandom;
    exp_sim = is_mem ? res : 32'h0;
    num_ctr = num_ctr + 64'd3;
    check("exu_ready_idle", 64'(exu_if.exu_ready), 64'd1);
    exu_if.exu_valid      = 1'b1;
    exu_if.exu_inst       = inst;
    exu_if.exu_result     = res;
    exu_if.exu_store_data = sdata;
    exu_if.exu_next_pc    = pc;
    exu_if.exu_num        = num_ctr;
    exp_q.push_back({inst, num_ctr, exp_wb, exp_sim, pc});
    tick();
    exu_if.exu_valid      = 1'b0;
    exu_if.exu_inst       = $urandom;
    exu_if.exu_result     = $urandom;
    exu_if.exu_store_data = $urandom;
    if (is_mem) begin
      for (int i = 0; i <= req_dly; i++) begin
        mem_if.mem_req_ready = (i == req_dly);
        check("req_valid",  64'(mem_if.mem_req_valid), 64'd1);
        check("req_addr",   64'(mem_if.mem_req_addr),  64'(res));
        check("req_wen",    64'(mem_if.mem_req_wen),   64'(is_st));
        check("req_wstrb",  64'(mem_if.mem_req_wstrb), is_st ? 64'(exp_strb) : 64'd0);
        if (is_st) check("req_wdata", 64'(mem_if.mem_req_wdata), 64'(exp_bus));
        check("exu_ready_busy", 64'(exu_if.exu_ready), 64'd0);
        check("hazard_inst",    64'(hazard),           64'(inst));
        tick();
      end
      mem_if.mem_req_ready = 1'b0;
      check("req_valid_wait", 64'(mem_if.mem_req_valid), 64'd0);
      mem_if.mem_resp_valid = 1'b1;
      mem_if.mem_resp_data  = rdata;
      mem_if.mem_resp_err   = err;
      tick();
      mem_if.mem_resp_valid = 1'b0;
      mem_if.mem_resp_err   = 1'b0;
      mem_if.mem_resp_data  = $urandom;
      if (err) exp_fault = 1'b1;
    end
    check("wbu_valid_lat", 64'(wbu_if.wbu_valid), 64'd1);
    for (int i = 0; i < out_dly; i++) begin
      exu_if.exu_valid = 1'b1;
      check("wbu_wdata_hold", 64'(wbu_if.wbu_wdata), 64'(exp_wb));
      check("wbu_inst_hold",  64'(wbu_if.wbu_inst),  64'(inst));
      check("exu_ready_out",  64'(exu_if.exu_ready), 64'd0);
      tick();
    end
    exu_if.exu_valid = 1'b0;
    wbu_if.wbu_ready = 1'b1;
    tick();
    wbu_if.wbu_ready = 1'b0;
    check("wbu_valid_done", 64'(wbu_if.wbu_valid), 64'd0);
    check("exu_ready_back", 64'(exu_if.exu_ready), 64'd1);
    check("lsu_fault",      64'(fault),            64'(exp_fault));
  endtask

  initial begin
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] addr, sd, rd, inst;
    bit          st;

    rst = 1'b1;
    exu_if.exu_valid = 1'b0; exu_if.exu_inst = '0; exu_if.exu_result = '0;
    exu_if.exu_store_data = '0; exu_if.exu_next_pc = '0; exu_if.exu_num = '0;
    mem_if.mem_req_ready = 1'b0; mem_if.mem_resp_valid = 1'b0;
    mem_if.mem_resp_data = '0; mem_if.mem_resp_err = 1'b0;
    wbu_if.wbu_ready = 1'b0;
    repeat (2) tick();
    check("rst_exu_ready", 64'(exu_if.exu_ready),     64'd1);
    check("rst_req_valid", 64'(mem_if.mem_req_valid), 64'd0);
    check("rst_wbu_valid", 64'(wbu_if.wbu_valid),     64'd0);
    check("rst_wbu_num",   wbu_if.wbu_num,            RST_NUM);
    check("rst_wbu_inst",  64'(wbu_if.wbu_inst),      64'd0);
    check("rst_wbu_wdata", 64'(wbu_if.wbu_wdata),     64'd0);
    check("rst_hazard",    64'(hazard),               64'd0);
    check("rst_fault",     64'(fault),                64'd0);
    check("rst_state",     64'(dbg_state),            64'(IDLE));
    rst = 1'b0;
    tick();

    run_inst(32'h0010_0093, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0, 32'h0000_1234, 4'h0, 32'h0);
    run_inst(32'h0000_0083, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0, 32'hFFFF_FF80, 4'h0, 32'h0);
    run_inst(32'h0000_4083, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0, 32'h0000_0080, 4'h0, 32'h0);
    run_inst(32'h0000_1023, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 0, 0, 0, 32'h0, 4'b1100, 32'hABCD_ABCD);
    run_inst(32'h0000_2083, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 5, 0, 32'hDEAD_BEEF, 4'h0, 32'h0);
    run_inst(32'h1234_50B7, 32'h1234_5000, 32'h0, 32'h0, 0, 0, 3, 32'h1234_5000, 4'h0, 32'h0);
    run_inst(32'h0000_0023, 32'h8000_0101, 32'hAABB_CC5A, 32'h0, 0, 1, 0, 32'h0, 4'b0010, 32'h5A5A_5A5A);
    run_inst(32'h0000_1083, 32'h8000_0006, 32'h0, 32'h8001_1234, 0, 0, 0, 32'hFFFF_8001, 4'h0, 32'h0);
    run_inst(32'h0000_5083, 32'h8000_0007, 32'h0, 32'hC000_0000, 0, 0, 1, 32'h0000_00C0, 4'h0, 32'h0);
    run_inst(32'h0000_2083, 32'h8000_0009, 32'h0, 32'h1122_3344, 0, 0, 0, 32'h0011_2233, 4'h0, 32'h0);

    for (int n = 0; n < 12; n++) begin
      st   = 1'($urandom_range(0, 1));
      off  = 2'($urandom_range(0, 3));
      f3   = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      addr = $urandom;
      addr[1:0] = off;
      sd   = $urandom;
      rd   = $urandom;
      inst = {15'($urandom), f3, 5'($urandom), st ? OP_STORE : OP_LOAD};
      run_inst(inst, addr, sd, rd, 0, $urandom_range(0, 2), $urandom_range(0, 2),
               st ? 32'h0 : ref_load(f3, off, rd), ref_strb(f3, off), ref_wdata(f3, sd));
    end

    // Reset while waiting for a response; the late response must be ignored.
    exu_if.exu_valid = 1'b1; exu_if.exu_inst = 32'h0000_2083; exu_if.exu_result = 32'h8000_0040;
    tick();
    exu_if.exu_valid = 1'b0;
    mem_if.mem_req_ready = 1'b1;
    tick();
    mem_if.mem_req_ready = 1'b0;
    check("abort_state_wait", 64'(dbg_state), 64'(WAIT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_req_valid", 64'(mem_if.mem_req_valid), 64'd0);
    mem_if.mem_resp_valid = 1'b1; mem_if.mem_resp_data = 32'hFFFF_FFFF; mem_if.mem_resp_err = 1'b1;
    tick();
    mem_if.mem_resp_valid = 1'b0; mem_if.mem_resp_err = 1'b0;
    tick();
    check("abort_state",     64'(dbg_state),          64'(IDLE));
    check("abort_wbu_valid", 64'(wbu_if.wbu_valid),   64'd0);
    check("abort_fault",     64'(fault),              64'd0);
    check("abort_wbu_wdata", 64'(wbu_if.wbu_wdata),   64'd0);
    check("abort_wbu_num",   wbu_if.wbu_num,          RST_NUM);
    exp_fault = 1'b0;

    run_inst(32'h0000_2083, 32'h8000_0020, 32'h0, 32'h5555_AAAA, 1, 0, 0, 32'h0, 4'h0, 32'h0);
    run_inst(32'h0010_0093, 32'h0000_0077, 32'h0, 32'h0, 0, 0, 0, 32'h0000_0077, 4'h0, 32'h0);
    check("fault_sticky", 64'(fault), 64'd1);

    repeat (2) tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
Load/store stage of the RV32E pipelined core, between EXU (upstream) and the write-back/register-file stage (downstream).
- Accepts one instruction at a time from EXU over a valid/ready handshake.
- For loads and stores, issues one request on a simple memory request/response port; it aligns store data and byte strobes, and extracts and extends load data.
- Passes the result, instruction word, next PC, instruction number and access address to WBU over a valid/ready handshake.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, data width (fixed 32; byte-strobe width DATA_WIDTH/8)
RESET_NUM, 0, reset value of held instruction number

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
exu_valid  in  1  EXU offers instruction
exu_ready  out  1  stage can accept (high iff state IDLE)
exu_inst  in  32  instruction word
exu_result  in  32  ALU result; effective address for load/store
exu_store_data  in  32  rs2 value for stores
exu_next_pc  in  32  PC after this instruction
exu_num  in  64  instruction sequence number
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  byte address (unaligned address passed unchanged)
mem_req_wen  out  1  1 = store, 0 = load
mem_req_wdata  out  32  lane-shifted store data
mem_req_wstrb  out  4  byte strobes (0 for loads)
mem_resp_valid  in  1  read data / write ack valid
mem_resp_data  in  32  read data word
mem_resp_err  in  1  access fault with response
wbu_valid  out  1  result offered to WBU
wbu_ready  in  1  WBU accepts
wbu_wdata  out  32  write-back value
wbu_inst  out  32  instruction word
wbu_next_pc  out  32  next PC
wbu_num  out  64  instruction number
wbu_sim_addr  out  32  memory address of access (0 for non-memory instructions)
lsu_hazard_inst  out  32  instruction held in the stage (0 when IDLE)
lsu_fault  out  1  sticky; set on mem_resp_err, cleared only by reset

Behaviour:
- States: IDLE, REQ, WAIT, OUT.
- Reset (synchronous): state IDLE; mem_req_valid 0; wbu_valid 0; all held registers and wbu_* outputs 0, except wbu_num = RESET_NUM; lsu_fault 0; exu_ready 1.
- Reset mid-access drops mem_req_valid in the next cycle. Any response arriving afterwards is ignored, because IDLE ignores mem_resp_valid.
- IDLE: on exu_valid && exu_ready, capture inst, result, store_data, next_pc and num.
  - opcode 0000011 (load) or 0100011 (store) -> REQ.
  - any other opcode -> OUT, with wbu_wdata = exu_result and wbu_sim_addr = 0.
- REQ: mem_req_valid = 1; addr, wen, wdata and wstrb held stable until mem_req_ready. On handshake -> WAIT. Back-to-back ready costs zero extra cycles in REQ.
- WAIT: on mem_resp_valid -> OUT.
  - Load: wbu_wdata = extended data.
  - Store: wbu_wdata = 0.
  - If mem_resp_err: wbu_wdata = 0 and lsu_fault is set.
  - A response received in REQ is ignored.
- OUT: wbu_valid = 1 with all wbu_* stable. On wbu_ready -> IDLE. Accept of a new EXU instruction resumes the following cycle (no same-cycle pass-through).
- Minimum latency from EXU handshake to wbu_valid:
  - non-memory: 1 cycle
  - memory: 3 cycles, with ready and response each arriving in the first possible cycle.
- Store alignment (off = addr[1:0], f3 = inst[14:12]):
  - SB (000): wstrb = 0001 << off; wdata = {4{data[7:0]}}.
  - SH (001): wstrb = (0011 << off)[3:0]; wdata = {2{data[15:0]}}.
  - SW (010): wstrb = 1111; wdata = data.
- Load extraction: shifted = resp_data >> (8*off).
  - LB: sign-extend shifted[7:0].
  - LH: sign-extend shifted[15:0].
  - LW: shifted.
  - LBU, LHU: zero-extend.
  - Unknown f3: treated as LW.
- Misaligned accesses (half with off = 3, word with off != 0) raise no exception. Strobes truncate to 4 bits and load upper bits shift in zero; results are deterministic per the rules above.
- lsu_hazard_inst = captured inst in REQ/WAIT/OUT, 0 in IDLE.

Decomposition:
- Package lsu_pkg:
  - opcode constants OP_LOAD, OP_STORE
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - 2-bit state encoding (IDLE = 0, REQ = 1, WAIT = 2, OUT = 3)
- One combinational sub-module, lsu_align: (f3, off, store_data, resp_data) -> (wstrb, wdata, load_value).
- The FSM and capture registers live in lsu_stage.

Test Plan:
- addi, exu_result = 0x0000_1234, wbu_ready = 1 -> wbu_valid 1 cycle after accept; wbu_wdata = 0x1234; wbu_sim_addr = 0; exu_ready back high the following cycle.
- LB addr 0x8000_0003, resp_data 0x80FF_0000 -> mem_req_wen 0, wstrb 0; wbu_wdata = 0xFFFF_FF80. Same stimulus with LBU -> 0x0000_0080.
- SH addr 0x8000_0002, store_data 0x1234_ABCD -> wstrb 1100; wdata 0xABCD_ABCD; wbu_wdata = 0; wbu_sim_addr = 0x8000_0002.
- mem_req_ready held low 5 cycles on LW -> mem_req_valid and addr stable all 5 cycles; single handshake; exu_ready low throughout.
- wbu_ready low 3 cycles in OUT -> wbu_* stable; exu_valid ignored; accept resumes only after the wbu handshake.
- Reset asserted in WAIT, then a stale mem_resp_valid arrives -> state IDLE, wbu_valid 0, lsu_fault 0. LW with mem_resp_err afterwards -> wbu_wdata = 0, lsu_fault = 1 and stays 1.
